// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   op_e     - operation encodings driven on the op input
//   state_e  - controller states
//   ITER_LAST, DIV0_LO - iteration bound and divide-by-zero quotient
//   mag32()  - two's-complement magnitude, applied only when is_signed is set
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [4:0]  ITER_LAST = 5'd31;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
//   acc_i/acc_o   64-bit accumulator. Multiply: {partial product, multiplier}
//                 shifted right one bit per step. Divide: low 32 bits hold the
//                 dividend, shifted left while quotient bits enter at bit 0.
//   opnd_i        multiplicand magnitude or divisor magnitude
//   is_div_i      selects divide step (only with MDU_DIV_EN)
//   rem_i/rem_o   33-bit partial remainder (only with MDU_DIV_EN)
// Build option: MDU_DIV_EN adds the restoring-divide step.
module mdu_step (
`ifdef MDU_DIV_EN
  input  logic        is_div_i,
  input  logic [32:0] rem_i,
  output logic [32:0] rem_o,
`endif
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  // Carry of the add lands in bit 63 after the right shift.
  logic [32:0] sum;
  assign sum = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? opnd_i : 32'd0)};

`ifdef MDU_DIV_EN
  logic [33:0] shifted;
  logic        ge;
  logic [32:0] diff;

  assign shifted = {rem_i, acc_i[31]};
  assign ge      = (shifted >= {2'b00, opnd_i});
  // When ge holds the true difference is below the divisor, so 33 bits suffice.
  assign diff    = shifted[32:0] - {1'b0, opnd_i};

  always_comb begin
    acc_o = {sum, acc_i[31:1]};
    rem_o = rem_i;
    if (is_div_i) begin
      acc_o = {acc_i[63:32], acc_i[30:0], ge};
      rem_o = ge ? diff : shifted[32:0];
    end
  end
`else
  assign acc_o = {sum, acc_i[31:1]};
`endif

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start, op        launch MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   src_a, src_b     rs / rt operands, needed in the start cycle only
//   wr_hi, wr_lo     MTHI / MTLO write of src_a (IDLE only)
//   busy, done       registered status; done pulses one cycle on result
//   hi, lo           architectural HI / LO
// Build option: MDU_DIV_EN enables the divider; without it DIV/DIVU pass
// through FIX in one cycle and leave HI/LO untouched.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, step_acc, prod;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        neg_lo_q, neg_lo_d;
  logic        is_div_q, is_div_d;
  logic        done_q, done_d;
  logic        op_signed, op_div;
  logic [31:0] mag_a, mag_b;
`ifdef MDU_DIV_EN
  logic [32:0] rem_q, rem_d, step_rem;
  logic        neg_hi_q, neg_hi_d;
  logic        div0_q, div0_d;
`endif

  assign op_div    = op[1];
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = mag32(src_a, op_signed);
  assign mag_b     = mag32(src_b, op_signed);
  assign prod      = neg_lo_q ? (~acc_q + 64'd1) : acc_q;

  mdu_step u_step (
`ifdef MDU_DIV_EN
    .is_div_i (is_div_q),
    .rem_i    (rem_q),
    .rem_o    (step_rem),
`endif
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
`ifdef MDU_DIV_EN
    rem_d    = rem_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = src_a;
        if (wr_lo) lo_d = src_a;
        if (start) begin
          cnt_d    = '0;
          is_div_d = op_div;
          neg_lo_d = op_signed & (src_a[31] ^ src_b[31]);
          // Multiply keeps the multiplier in the low half; divide keeps the dividend.
          acc_d    = {32'd0, (op_div ? mag_a : mag_b)};
          opnd_d   = op_div ? mag_b : mag_a;
`ifdef MDU_DIV_EN
          rem_d    = '0;
          neg_hi_d = op_signed & op_div & src_a[31];
          div0_d   = op_div & (src_b == 32'd0);
          state_d  = CALC;
`else
          state_d  = op_div ? FIX : CALC;
`endif
        end
      end
      CALC: begin
        acc_d = step_acc;
`ifdef MDU_DIV_EN
        rem_d = step_rem;
`endif
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
`ifdef MDU_DIV_EN
        else begin
          // Divide-by-zero: all trial subtracts succeed, so the remainder path
          // already reproduces src_a; only the quotient needs overriding.
          lo_d = div0_q ? DIV0_LO : (neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
          hi_d = neg_hi_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      rem_q    <= '0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      rem_q    <= rem_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
